control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microprogrammed control unit directly upstream of the processor datapath.
- Consumes the instruction register contents and a zero flag, and produces the 23-bit control word that drives register loads, bus source select, address select, ALU op, PC increment and AC input mux.
- Also drives the data-RAM write strobe and a halt indication.
- Implemented as a fetch/decode/execute FSM with a per-instruction micro-step counter.

Parameters:
- CW, 23, control word width; fixed layout below.
- OPW, 8, opcode width taken from ir[OPW-1:0].
- FETCH_WAIT, 0, extra IRAM wait cycles inserted in FETCH (0..3).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- ir  input  16  instruction register value; opcode = ir[7:0].
- z_flag  input  1  1 when AC == 0; sampled in EXEC.
- control  output  23  datapath control word.
- dram_we  output  1  data-RAM write enable.
- halted  output  1  high while in HALT.
- illegal  output  1  sticky; set on undecoded opcode.

Behaviour:
- Interface: one clock (`clock`); reset is synchronous and active-low (`reset_n`).
- Control word layout:
  - [0] reserved 0; [1] reserved 0.
  - [7:2] bus source code: 0 none, 1 AR, 2 PC, 3 DR, 4 R, 5 AC, 6 DRAM, 7 IRAM, 8 IR.
  - [9:8] ALU op: 01 add, 10 sub, 11 inc. Bit 8 also serves as PC increment.
  - [14] R load; [15] AR load; [16] DR load; [17] AC load; [18] PC load; [19] IR load.
  - [21:20] address select: 00 PC, 01 AR.
  - [22] AC source: 1 ALU, 0 bus.
  - [13:10] always 0.
- Outputs are registered: the control word for state S appears in the cycle S is occupied. Unlisted bits are 0.
- Reset (`reset_n` low at an edge): state = FETCH, step = 0, control = 0, dram_we = 0, halted = 0, illegal = 0. Reset mid-instruction aborts it; no partial writes occur after the reset edge.
- States: FETCH, INC, DECODE, EXEC, HALT.
  - FETCH: addr sel PC, bus IRAM, IR load. Held FETCH_WAIT extra cycles with IR load only in the last cycle.
  - INC: PC load with [8]=1 (PC+1).
  - DECODE: control = 0; latch opcode; step = 0.
  - EXEC: micro-steps per opcode, then back to FETCH.
- Opcodes:
  - 0x00 NOP: 1 step, control 0.
  - 0x01 LDAC, 2 steps:
    - step 0: addr AR, bus DRAM, DR load.
    - step 1: bus DR, AC load, [22]=0.
  - 0x02 STAC: bus AC, addr AR, dram_we = 1 for exactly one cycle.
  - 0x03 MVACR: bus AC, R load.
  - 0x04 MVRAC: bus R, AC load, [22]=0.
  - 0x05 ADD: bus R, ALU 01, AC load, [22]=1.
  - 0x06 SUB: as ADD with ALU 10.
  - 0x07 MVACAR: bus AC, AR load.
  - 0x08 JMPZ: if z_flag then bus R, PC load with [8]=0; else control 0.
  - 0x09 JMP: unconditional form of JMPZ.
  - 0x0A INAC: ALU 11, AC load, [22]=1.
  - 0xFF HALT: go to HALT. HALT is held until reset; halted = 1 and control = 0 there.
- Undecoded opcode: executes as NOP, sets illegal (cleared only by reset).
- Cycles per instruction with FETCH_WAIT = 0: 4 for 1-step ops, 5 for LDAC.
- Never assert more than one bus source. Never assert PC load and IR load in the same cycle.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- When defined: adds input `step_req` (1 bit). FETCH is entered only after a cycle with step_req = 1. The FSM waits in a new IDLE state with control = 0, so one instruction executes per pulse. step_req held high runs continuously.
- When undefined: no port, no IDLE state; FETCH follows EXEC directly.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles, release -> control = 0x000000 on the reset cycles; first FETCH word has bit19 = 1, [7:2] = 7, [21:20] = 00.
- ADD: ir = 0x0005 -> in EXEC, control[17] = 1, [22] = 1, [9:8] = 01, [7:2] = 4; total instruction length 4 cycles.
- LDAC then STAC: ir = 0x0001 -> 2 EXEC cycles with DR load, then AC load. ir = 0x0002 -> dram_we high for exactly 1 cycle with [21:20] = 01.
- JMPZ: ir = 0x0008 with z_flag = 1 -> PC load, [7:2] = 4, [8] = 0. With z_flag = 0 -> control 0 in EXEC.
- Illegal and halt: ir = 0x0042 -> illegal = 1, flow continues. ir = 0x00FF -> halted = 1 and control = 0 for 10+ cycles. reset_n = 0 clears both.
- Reset during LDAC step 0 -> next cycle control = 0; after release, restarts at FETCH.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Datapath-facing bundle of the control sequencer: instruction/flag in, control word and strobes out.
interface control_sequencer_if #(
  parameter int CW = 23
);
  logic [15:0]   ir;
  logic          z_flag;
  logic [CW-1:0] control;
  logic          dram_we;
  logic          halted;
  logic          illegal;

  modport master (output ir, z_flag, input control, dram_we, halted, illegal);
  modport slave  (input ir, z_flag, output control, dram_we, halted, illegal);
endinterface

// File: rtl/control_sequencer.sv
// Microprogrammed FETCH/INC/DECODE/EXEC/HALT control unit with registered control word outputs.
// Optional CU_SINGLE_STEP_EN adds step_req and an IDLE state gating each instruction fetch.
module control_sequencer #(
  parameter int CW         = 23,
  parameter int OPW        = 8,
  parameter int FETCH_WAIT = 0
) (
  input  logic clock,
  input  logic reset_n,
`ifdef CU_SINGLE_STEP_EN
  input  logic step_req,
`endif
  control_sequencer_if.slave cs
);

`ifdef CU_SINGLE_STEP_EN
  typedef enum logic [2:0] {S_FETCH, S_INC, S_DECODE, S_EXEC, S_HALT, S_IDLE} state_e;
  localparam state_e S_AFTER = S_IDLE;
`else
  typedef enum logic [2:0] {S_FETCH, S_INC, S_DECODE, S_EXEC, S_HALT} state_e;
  localparam state_e S_AFTER = S_FETCH;
`endif

  localparam int B_ALU0 = 8, B_ALU1 = 9, B_RLD = 14, B_ARLD = 15, B_DRLD = 16;
  localparam int B_ACLD = 17, B_PCLD = 18, B_IRLD = 19, B_ASEL = 20, B_ACSRC = 22;

  localparam logic [5:0] BUS_PC = 6'd2, BUS_DR = 6'd3, BUS_R = 6'd4, BUS_AC = 6'd5;
  localparam logic [5:0] BUS_DRAM = 6'd6, BUS_IRAM = 6'd7;

  localparam logic [OPW-1:0] OP_NOP   = OPW'(8'h00);
  localparam logic [OPW-1:0] OP_LDAC  = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_STAC  = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_MVACR = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_MVRAC = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_MVACAR= OPW'(8'h07);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_INAC  = OPW'(8'h0A);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(8'hFF);

  localparam logic [1:0] FW = 2'(FETCH_WAIT);

  state_e         r_state, w_nstate;
  logic [1:0]     r_wait,  w_nwait;
  logic           r_step,  w_nstep;
  logic [OPW-1:0] r_op,    w_nop;
  logic           r_boot;

  logic [CW-1:0]  r_control, w_control;
  logic           r_dram_we, w_dram_we;
  logic           r_halted,  w_halted;
  logic           r_illegal, w_illegal_op;

  // r_boot marks the reset slot so the first FETCH word is issued on the first edge out of reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_wait    <= 2'd0;
      r_step    <= 1'b0;
      r_op      <= '0;
      r_boot    <= 1'b1;
      r_control <= '0;
      r_dram_we <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_wait    <= w_nwait;
      r_step    <= w_nstep;
      r_op      <= w_nop;
      r_boot    <= 1'b0;
      r_control <= w_control;
      r_dram_we <= w_dram_we;
      r_halted  <= w_halted;
      r_illegal <= r_illegal | w_illegal_op;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nwait  = r_wait;
    w_nstep  = r_step;
    w_nop    = r_op;
    if (r_boot) begin
      w_nstate = S_AFTER;
      w_nwait  = 2'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_wait == FW) w_nstate = S_INC;
          else              w_nwait  = r_wait + 2'd1;
        end
        S_INC:    w_nstate = S_DECODE;
        S_DECODE: begin
          w_nstate = S_EXEC;
          w_nstep  = 1'b0;
          w_nop    = cs.ir[OPW-1:0];
        end
        S_EXEC: begin
          if (r_op == OP_LDAC && !r_step) begin
            w_nstep = 1'b1;
          end else if (r_op == OP_HALT) begin
            w_nstate = S_HALT;
          end else begin
            w_nstate = S_AFTER;
            w_nwait  = 2'd0;
          end
        end
        S_HALT:   w_nstate = S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_IDLE: begin
          if (step_req) begin
            w_nstate = S_FETCH;
            w_nwait  = 2'd0;
          end
        end
`endif
        default:  w_nstate = S_FETCH;
      endcase
    end
  end

  // Decode the word for the state about to be entered so outputs line up with the state register.
  always_comb begin
    w_control    = '0;
    w_dram_we    = 1'b0;
    w_halted     = 1'b0;
    w_illegal_op = 1'b0;
    case (w_nstate)
      S_FETCH: begin
        w_control[7:2] = BUS_IRAM;
        w_control[B_IRLD] = (w_nwait == FW);
      end
      S_INC: begin
        w_control[B_PCLD] = 1'b1;
        w_control[B_ALU0] = 1'b1;
      end
      S_EXEC: begin
        case (w_nop)
          OP_NOP: ;
          OP_LDAC: begin
            if (!w_nstep) begin
              w_control[B_ASEL] = 1'b1;
              w_control[7:2]    = BUS_DRAM;
              w_control[B_DRLD] = 1'b1;
            end else begin
              w_control[7:2]    = BUS_DR;
              w_control[B_ACLD] = 1'b1;
            end
          end
          OP_STAC: begin
            w_control[7:2]    = BUS_AC;
            w_control[B_ASEL] = 1'b1;
            w_dram_we         = 1'b1;
          end
          OP_MVACR: begin
            w_control[7:2]   = BUS_AC;
            w_control[B_RLD] = 1'b1;
          end
          OP_MVRAC: begin
            w_control[7:2]    = BUS_R;
            w_control[B_ACLD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_control[7:2]     = BUS_R;
            w_control[9:8]     = (w_nop == OP_ADD) ? 2'b01 : 2'b10;
            w_control[B_ACLD]  = 1'b1;
            w_control[B_ACSRC] = 1'b1;
          end
          OP_MVACAR: begin
            w_control[7:2]    = BUS_AC;
            w_control[B_ARLD] = 1'b1;
          end
          OP_JMPZ, OP_JMP: begin
            if (w_nop == OP_JMP || cs.z_flag) begin
              w_control[7:2]    = BUS_R;
              w_control[B_PCLD] = 1'b1;
            end
          end
          OP_INAC: begin
            w_control[B_ALU1]  = 1'b1;
            w_control[B_ALU0]  = 1'b1;
            w_control[B_ACLD]  = 1'b1;
            w_control[B_ACSRC] = 1'b1;
          end
          OP_HALT: ;
          default: w_illegal_op = 1'b1;
        endcase
      end
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  assign cs.control = r_control;
  assign cs.dram_we = r_dram_we;
  assign cs.halted  = r_halted;
  assign cs.illegal = r_illegal;

  logic w_unused;
  assign w_unused = ^{cs.ir[15:OPW], BUS_PC};

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle output words are queued per instruction and drained at negedges.
module tb_control_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  control_sequencer_if #(.CW(23)) bus ();

  control_sequencer #(.CW(23), .OPW(8), .FETCH_WAIT(0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cs      (bus)
  );

  typedef logic [25:0] exp_t;
  exp_t  sbq[$];
  string nmq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  m_ill = 1'b0;

  function automatic exp_t mk(input logic ill, input logic [22:0] c, input logic we, input logic h);
    return {ill, h, we, c};
  endfunction

  function automatic exp_t observed();
    return {bus.illegal, bus.halted, bus.dram_we, bus.control};
  endfunction

  task automatic push(input string nm, input logic [22:0] c, input logic we, input logic h);
    sbq.push_back(mk(m_ill, c, we, h));
    nmq.push_back(nm);
  endtask

  // Drive one instruction at the negedge of its FETCH cycle and queue its expected words.
  task automatic push_instr(input logic [15:0] ir, input logic z);
    bus.ir = ir;
    bus.z_flag = z;
    push("fetch", 23'h08001C, 1'b0, 1'b0);
    push("inc", 23'h040100, 1'b0, 1'b0);
    push("decode", 23'h000000, 1'b0, 1'b0);
    case (ir[7:0])
      8'h00: push("nop", 23'h000000, 1'b0, 1'b0);
      8'h01: begin
        push("ldac_s0", 23'h110018, 1'b0, 1'b0);
        push("ldac_s1", 23'h02000C, 1'b0, 1'b0);
      end
      8'h02: push("stac", 23'h100014, 1'b1, 1'b0);
      8'h03: push("mvacr", 23'h004014, 1'b0, 1'b0);
      8'h04: push("mvrac", 23'h020010, 1'b0, 1'b0);
      8'h05: push("add", 23'h420110, 1'b0, 1'b0);
      8'h06: push("sub", 23'h420210, 1'b0, 1'b0);
      8'h07: push("mvacar", 23'h008014, 1'b0, 1'b0);
      8'h08: push(z ? "jmpz_t" : "jmpz_f", z ? 23'h040010 : 23'h000000, 1'b0, 1'b0);
      8'h09: push("jmp", 23'h040010, 1'b0, 1'b0);
      8'h0A: push("inac", 23'h420300, 1'b0, 1'b0);
      8'hFF: push("halt_exec", 23'h000000, 1'b0, 1'b0);
      default: begin
        m_ill = 1'b1;
        push("illegal_exec", 23'h000000, 1'b0, 1'b0);
      end
    endcase
  endtask

  // Compare queued words one per cycle; leaves the bench at the negedge after the last word unless hold_last.
  task automatic drain(input bit hold_last);
    exp_t  e;
    string nm;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      nm = nmq.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, observed(), e);
      end
      if (!(hold_last && sbq.size() == 0)) @(negedge clock);
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    m_ill = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      push("reset_cycle", 23'h000000, 1'b0, 1'b0);
      if (i == cycles - 1) reset_n = 1'b1;
      drain(1'b1);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset(2);
  endtask

  task automatic test_alu();
    push_instr(16'h0005, 1'b0); drain(1'b0);
    push_instr(16'h0006, 1'b1); drain(1'b0);
    push_instr(16'h000A, 1'b0); drain(1'b0);
    push_instr(16'h0003, 1'b0); drain(1'b0);
    push_instr(16'h0004, 1'b0); drain(1'b0);
    push_instr(16'h0007, 1'b0); drain(1'b0);
    push_instr(16'h0000, 1'b0); drain(1'b0);
  endtask

  task automatic test_ldac_stac();
    push_instr(16'h0001, 1'b0); drain(1'b0);
    push_instr(16'h0002, 1'b0); drain(1'b0);
    push("after_stac_fetch", 23'h08001C, 1'b0, 1'b0);
    drain(1'b1);
  endtask

  task automatic test_jump();
    push_instr(16'h0008, 1'b1); drain(1'b0);
    push_instr(16'h0008, 1'b0); drain(1'b0);
    push_instr(16'h0009, 1'b0); drain(1'b0);
  endtask

  task automatic test_illegal_halt();
    push_instr(16'h0042, 1'b0); drain(1'b0);
    push_instr(16'h0005, 1'b0); drain(1'b0);
    push_instr(16'h00FF, 1'b0);
    for (int i = 0; i < 12; i++) push("halt_hold", 23'h000000, 1'b0, 1'b1);
    drain(1'b1);
    bus.ir = 16'h0005;
    apply_reset(1);
    push_instr(16'h0000, 1'b0); drain(1'b0);
  endtask

  task automatic test_reset_mid_ldac();
    push_instr(16'h0001, 1'b0);
    void'(sbq.pop_back());
    void'(nmq.pop_back());
    drain(1'b1);
    apply_reset(1);
    push_instr(16'h0005, 1'b0); drain(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [0:12];
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A, 8'h3C, 8'hA5};
    for (int i = 0; i < 30; i++) begin
      push_instr({8'($urandom), ops[$urandom_range(0, 12)]}, 1'($urandom));
      drain(1'b0);
    end
  endtask

  initial begin
    bus.ir = 16'h0000;
    bus.z_flag = 1'b0;
    @(negedge clock);
    test_reset();
    test_alu();
    test_ldac_stac();
    test_jump();
    test_illegal_halt();
    test_reset_mid_ldac();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
